calc_key_sequencer: RTL and testbench

Parametrised key-sequencing controller for the calculator datapath, successor to the original compute control FSM. It debounces raw front-panel keys, turns clean key presses into events and runs the operand/operator state machine. It drives the register-file and display control lines as either one-cycle pulses or legacy toggles. It also adds operator selection, chained operations and an error indication.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/key_debounce.sv | 37 +++
 rtl/calc_key_sequencer.sv | 133 +++++++++++++
 tb/tb_calc_key_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator key sequencer.
// Key-vector bit positions, FSM state encoding and output-mode selectors.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRST,
    ST_LOADED,
    ST_OPSEL,
    ST_ENTRY
  } calc_state_t;

  // Bit positions of each key in the debounced key vector; operators follow EV_OP_BASE.
  localparam int EV_NUMBER   = 0;
  localparam int EV_ENTER    = 1;
  localparam int EV_TOTAL    = 2;
  localparam int EV_CLEAR    = 3;
  localparam int EV_OP_BASE  = 4;

  localparam bit PULSE  = 1'b0;
  localparam bit TOGGLE = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: the filtered level follows raw after DEBOUNCE consecutive
// differing samples; rise is a one-cycle flag coincident with a filtered rising edge.
module key_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        cnt   <= '0;
        level <= raw;
        rise  <= raw;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_key_sequencer.sv
// Key-sequencing controller: debounces panel keys, prioritises key events and
// runs the operand/operator FSM that drives the register-file and display controls.
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int NUM_OPS    = 4,
  parameter int DEBOUNCE   = 4,
  parameter bit TOGGLE_OUT = PULSE,
  localparam int OP_W      = $clog2(NUM_OPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_number,
  input  logic               key_enter,
  input  logic               key_total,
  input  logic               key_clear,
  input  logic [NUM_OPS-1:0] key_op,
  output logic               store,
  output logic               update,
  output logic               clr,
  output logic               show,
  output logic [OP_W-1:0]    op_sel,
  output logic               op_valid,
  output logic               err
);

  localparam int NUM_KEYS = EV_OP_BASE + NUM_OPS;

  logic [NUM_KEYS-1:0] raw_keys;
  logic [NUM_KEYS-1:0] key_rise;
  logic [NUM_KEYS-1:0] key_level_unused;
  logic [NUM_OPS-1:0]  op_rise;
  logic [OP_W-1:0]     op_idx;
  calc_state_t         state;

  always_comb begin
    raw_keys                          = '0;
    raw_keys[EV_NUMBER]               = key_number;
    raw_keys[EV_ENTER]                = key_enter;
    raw_keys[EV_TOTAL]                = key_total;
    raw_keys[EV_CLEAR]                = key_clear;
    raw_keys[EV_OP_BASE +: NUM_OPS]   = key_op;
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_keys[i]),
      .level(key_level_unused[i]),
      .rise (key_rise[i])
    );
  end

  // Lowest-numbered operator wins when several rise together.
  always_comb begin
    op_rise = key_rise[EV_OP_BASE +: NUM_OPS];
    op_idx  = '0;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (op_rise[i]) op_idx = OP_W'(i);
    end
  end

  function automatic logic fire(input logic cur);
    return (TOGGLE_OUT == TOGGLE) ? ~cur : 1'b1;
  endfunction

  function automatic logic rest(input logic cur);
    return (TOGGLE_OUT == TOGGLE) ? cur : 1'b0;
  endfunction

  // The if/else chain implements clear > enter > op > number; total is handled on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      store    <= 1'b0;
      update   <= 1'b0;
      clr      <= 1'b0;
      show     <= 1'b0;
      err      <= 1'b0;
      op_valid <= 1'b0;
      op_sel   <= '0;
    end else begin
      store  <= rest(store);
      update <= rest(update);
      clr    <= rest(clr);
      err    <= 1'b0;

      if (key_rise[EV_TOTAL]) show <= ~show;

      if (key_rise[EV_CLEAR]) begin
        clr      <= fire(clr);
        state    <= ST_IDLE;
        op_valid <= 1'b0;
        op_sel   <= '0;
      end else if (key_rise[EV_ENTER]) begin
        case (state)
          ST_IDLE, ST_FIRST, ST_LOADED: begin
            store <= fire(store);
            state <= ST_LOADED;
          end
          ST_OPSEL: err <= 1'b1;
          ST_ENTRY: begin
            update <= fire(update);
            state  <= ST_LOADED;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (|op_rise) begin
        case (state)
          ST_LOADED, ST_OPSEL, ST_ENTRY: begin
            if (state == ST_ENTRY) update <= fire(update);
            op_sel   <= op_idx;
            op_valid <= 1'b1;
            state    <= ST_OPSEL;
          end
          default: ;
        endcase
      end else if (key_rise[EV_NUMBER]) begin
        case (state)
          ST_IDLE:   state <= ST_FIRST;
          ST_LOADED: begin
            if (op_valid) state <= ST_ENTRY;
            else          err   <= 1'b1;
          end
          ST_OPSEL:  state <= ST_ENTRY;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Bench for calc_key_sequencer: a pulse-mode and a toggle-mode instance share the
// same stimulus and are compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_calc_key_sequencer;

  localparam int NUM_OPS = 4;
  localparam int D       = 4;
  localparam int OP_W    = 2;
  localparam int NK      = 4 + NUM_OPS;

  localparam logic [NK-1:0] K_NUM = 8'h01;
  localparam logic [NK-1:0] K_ENT = 8'h02;
  localparam logic [NK-1:0] K_TOT = 8'h04;
  localparam logic [NK-1:0] K_CLR = 8'h08;
  localparam logic [NK-1:0] K_OP0 = 8'h10;
  localparam logic [NK-1:0] K_OP1 = 8'h20;
  localparam logic [NK-1:0] K_OP2 = 8'h40;
  localparam logic [NK-1:0] K_OP3 = 8'h80;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] raw = '0;

  always #5 clk = ~clk;

  logic            store_p, update_p, clr_p, show_p, op_valid_p, err_p;
  logic [OP_W-1:0] op_sel_p;
  logic            store_t, update_t, clr_t, show_t, op_valid_t, err_t;
  logic [OP_W-1:0] op_sel_t;

  calc_key_sequencer #(.NUM_OPS(NUM_OPS), .DEBOUNCE(D), .TOGGLE_OUT(1'b0)) dut_p (
    .clk(clk), .rst(rst),
    .key_number(raw[0]), .key_enter(raw[1]), .key_total(raw[2]), .key_clear(raw[3]),
    .key_op(raw[NK-1:4]),
    .store(store_p), .update(update_p), .clr(clr_p), .show(show_p),
    .op_sel(op_sel_p), .op_valid(op_valid_p), .err(err_p)
  );

  calc_key_sequencer #(.NUM_OPS(NUM_OPS), .DEBOUNCE(D), .TOGGLE_OUT(1'b1)) dut_t (
    .clk(clk), .rst(rst),
    .key_number(raw[0]), .key_enter(raw[1]), .key_total(raw[2]), .key_clear(raw[3]),
    .key_op(raw[NK-1:4]),
    .store(store_t), .update(update_t), .clr(clr_t), .show(show_t),
    .op_sel(op_sel_t), .op_valid(op_valid_t), .err(err_t)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_FIRST = 1, M_LOADED = 2, M_OPSEL = 3, M_ENTRY = 4;

  logic [NK-1:0]   lvl_m, pend_m;
  logic [D-1:0]    hist_m [NK];
  int              st_m;
  logic            e_store, e_update, e_clr, e_show, e_err, e_valid;
  logic [OP_W-1:0] e_sel;
  logic            t_store, t_update, t_clr;
  bit              model_ready = 1'b0;

  task automatic model_step();
    int idx;
    if (rst) begin
      lvl_m = '0; pend_m = '0;
      for (int j = 0; j < NK; j++) hist_m[j] = '0;
      st_m = M_IDLE;
      {e_store, e_update, e_clr, e_show, e_err, e_valid} = '0;
      e_sel = '0;
      {t_store, t_update, t_clr} = '0;
    end else begin
      {e_store, e_update, e_clr, e_err} = '0;
      idx = -1;
      for (int i = NUM_OPS - 1; i >= 0; i--) if (pend_m[4 + i]) idx = i;
      if (pend_m[2]) e_show = ~e_show;
      if (pend_m[3]) begin
        e_clr = 1'b1; st_m = M_IDLE; e_valid = 1'b0; e_sel = '0;
      end else if (pend_m[1]) begin
        if (st_m == M_OPSEL)      e_err = 1'b1;
        else if (st_m == M_ENTRY) begin e_update = 1'b1; st_m = M_LOADED; end
        else                      begin e_store = 1'b1;  st_m = M_LOADED; end
      end else if (idx >= 0) begin
        if (st_m == M_LOADED || st_m == M_OPSEL || st_m == M_ENTRY) begin
          if (st_m == M_ENTRY) e_update = 1'b1;
          e_sel = OP_W'(idx); e_valid = 1'b1; st_m = M_OPSEL;
        end
      end else if (pend_m[0]) begin
        if (st_m == M_IDLE)        st_m = M_FIRST;
        else if (st_m == M_OPSEL)  st_m = M_ENTRY;
        else if (st_m == M_LOADED) begin
          if (e_valid) st_m = M_ENTRY;
          else         e_err = 1'b1;
        end
      end
      t_store ^= e_store; t_update ^= e_update; t_clr ^= e_clr;
      // A level flips once the last D samples all disagree with it.
      for (int j = 0; j < NK; j++) begin
        hist_m[j] = {hist_m[j][D-2:0], raw[j]};
        pend_m[j] = 1'b0;
        if (hist_m[j] == {D{~lvl_m[j]}}) begin
          lvl_m[j]  = ~lvl_m[j];
          pend_m[j] = lvl_m[j];
        end
      end
    end
    model_ready = 1'b1;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (model_ready) begin
      check("store_p",    store_p,    e_store);
      check("update_p",   update_p,   e_update);
      check("clr_p",      clr_p,      e_clr);
      check("show_p",     show_p,     e_show);
      check("err_p",      err_p,      e_err);
      check("op_valid_p", op_valid_p, e_valid);
      check("op_sel_p",   op_sel_p,   e_sel);
      check("store_t",    store_t,    t_store);
      check("update_t",   update_t,   t_update);
      check("clr_t",      clr_t,      t_clr);
      check("show_t",     show_t,     e_show);
      check("err_t",      err_t,      e_err);
      check("op_valid_t", op_valid_t, e_valid);
      check("op_sel_t",   op_sel_t,   e_sel);
    end
  end

  // ---------------- directed stimulus ----------------
  int              seen_store, seen_update, seen_clr, seen_err;
  logic [OP_W-1:0] upd_sel;

  task automatic clear_seen();
    seen_store = 0; seen_update = 0; seen_clr = 0; seen_err = 0; upd_sel = '0;
  endtask

  task automatic drive(input logic [NK-1:0] mask, input int cycles);
    raw = mask;
    repeat (cycles) begin
      @(negedge clk);
      if (store_p) seen_store++;
      if (update_p) begin seen_update++; upd_sel = op_sel_p; end
      if (clr_p) seen_clr++;
      if (err_p) seen_err++;
    end
  endtask

  task automatic press(input logic [NK-1:0] mask, input int hold);
    clear_seen();
    drive(mask, hold);
    drive('0, D + 2);
  endtask

  initial begin
    clear_seen();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_store", store_p, 0);
    check("rst_show", show_p, 0);
    check("rst_op_valid", op_valid_p, 0);
    check("rst_op_sel", op_sel_p, 0);
    check("rst_err", err_p, 0);
    rst = 1'b0;

    // Short press is filtered out; a full press stores exactly at edge k+D.
    press(K_ENT, D - 1);
    check("short_press_store", seen_store, 0);
    drive(K_ENT, D);
    check("store_before_k4", store_p, 0);
    drive('0, 1);
    check("store_at_k4", store_p, 1);
    drive('0, 1);
    check("store_one_cycle", store_p, 0);
    drive('0, D + 2);

    press(K_CLR, D);
    check("clear_pulse", seen_clr, 1);

    // number, enter, op[2], number, enter
    press(K_NUM, D);
    press(K_ENT, D);
    check("seq_store", seen_store, 1);
    press(K_OP2, D);
    check("seq_op_sel", op_sel_p, 2);
    check("seq_op_valid", op_valid_p, 1);
    press(K_NUM, D);
    press(K_ENT, D);
    check("seq_update", seen_update, 1);

    // Chained operation from ENTRY, then enter in OPSEL is illegal.
    press(K_NUM, D);
    press(K_OP1, D);
    check("chain_update", seen_update, 1);
    check("chain_sel_same_cycle", upd_sel, 1);
    press(K_ENT, D);
    check("opsel_enter_err", seen_err, 1);
    check("opsel_enter_no_store", seen_store, 0);

    // Back-to-back events: op then enter one cycle later from ENTRY.
    press(K_NUM, D);
    clear_seen();
    drive(K_OP3, 1);
    drive(K_OP3 | K_ENT, D - 1);
    drive(K_ENT, 1);
    drive('0, D + 2);
    check("b2b_update", seen_update, 1);
    check("b2b_err", seen_err, 1);

    // clear beats enter; total is processed alongside.
    press(K_CLR | K_ENT | K_TOT, D);
    check("prio_clr", seen_clr, 1);
    check("prio_no_store", seen_store, 0);
    check("prio_show", show_p, 1);
    check("prio_op_valid", op_valid_p, 0);

    // Number in LOADED without an operator is an error; op[1]+op[3] picks op 1.
    press(K_ENT, D);
    press(K_NUM, D);
    check("loaded_number_err", seen_err, 1);
    press(K_OP1 | K_OP3, D);
    check("multi_op_sel", op_sel_p, 1);
    check("multi_op_valid", op_valid_p, 1);

    // Reset mid-press aborts with no pulse.
    press(K_NUM, D);
    clear_seen();
    drive(K_ENT, D - 1);
    rst = 1'b1;
    drive(K_ENT, 2);
    rst = 1'b0;
    drive('0, D + 2);
    check("abort_no_update", seen_update, 0);
    check("abort_op_valid", op_valid_p, 0);

    // Toggle-mode store levels across three enters from IDLE.
    press(K_ENT, D);
    check("toggle_store_1", store_t, 1);
    press(K_ENT, D);
    check("toggle_store_2", store_t, 0);
    press(K_ENT, D);
    check("toggle_store_3", store_t, 1);

    // Enter held through reset is a fresh press after reset releases.
    rst = 1'b1;
    drive(K_ENT, 3);
    rst = 1'b0;
    drive(K_ENT, D);
    check("held_rst_before", store_p, 0);
    drive(K_ENT, 1);
    check("held_rst_store_p", store_p, 1);
    check("held_rst_store_t", store_t, 1);
    drive('0, D + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
